// File: rtl/round_controller.sv
// round_controller: game-flow sequencer for the answer/timer game.
// Drives the countdown timer (restart + speed), tracks round and score,
// and steps each round through ARM -> RUN -> LOAD, ending in OVER.
module round_controller #(
  parameter int NUM_ROUNDS  = 10,
  parameter int FAST_ROUND  = 5,
  parameter int LOAD_CYCLES = 50_000_000,
  parameter int CNT_W       = 28
) (
  input  logic       clk,
  input  logic       reset_n,        // active-high despite the name
  input  logic       start,
  input  logic       answer_valid,
  input  logic       answer_correct,
  input  logic       time_up,
  output logic       timer_reset,
  output logic [1:0] frequency,
  output logic [3:0] round,
  output logic [7:0] score,
  output logic       loading,
  output logic       game_over,
  output logic       round_end,
  output logic [1:0] outcome
);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_RUN, S_LOAD, S_OVER} state_t;

  localparam logic [3:0]       LAST_RND  = 4'(NUM_ROUNDS - 1);
  localparam logic [3:0]       FAST_RND  = 4'(FAST_ROUND);
  localparam logic [CNT_W-1:0] LOAD_INIT = CNT_W'(LOAD_CYCLES - 1);

  localparam logic [1:0] FREQ_SLOW   = 2'b00;
  localparam logic [1:0] FREQ_FAST   = 2'b11;
  localparam logic [1:0] FREQ_FROZEN = 2'b01;

  localparam logic [1:0] OUT_NONE    = 2'b00;
  localparam logic [1:0] OUT_CORRECT = 2'b01;
  localparam logic [1:0] OUT_WRONG   = 2'b10;
  localparam logic [1:0] OUT_TIMEOUT = 2'b11;

  state_t           state;
  logic [1:0]       guard;     // RUN cycles elapsed, saturating at 2
  logic             tu_prev;   // time_up last cycle, for edge detection
  logic [CNT_W-1:0] dly_cnt;
  logic             timeout;

  function automatic logic [1:0] run_speed(input logic [3:0] r);
    return (r < FAST_RND) ? FREQ_SLOW : FREQ_FAST;
  endfunction

  // A time_up edge only counts once the timer has had time to leave its
  // held-at-30 state; earlier edges are leftovers from the restart.
  assign timeout = time_up & ~tu_prev & (guard == 2'd2);

  // Round sequencer with registered outputs
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state       <= S_IDLE;
      timer_reset <= 1'b1;
      frequency   <= FREQ_FROZEN;
      round       <= '0;
      score       <= '0;
      loading     <= 1'b0;
      game_over   <= 1'b0;
      round_end   <= 1'b0;
      outcome     <= OUT_NONE;
      dly_cnt     <= '0;
      guard       <= '0;
      tu_prev     <= 1'b1;
    end else begin
      round_end <= 1'b0;
      tu_prev   <= time_up;
      case (state)
        S_IDLE, S_OVER: begin
          timer_reset <= 1'b1;
          if (start) begin
            score     <= '0;
            round     <= '0;
            outcome   <= OUT_NONE;
            game_over <= 1'b0;
            frequency <= run_speed(4'd0);
            guard     <= '0;
            state     <= S_ARM;
          end
        end
        S_ARM: begin
          timer_reset <= 1'b0;
          frequency   <= run_speed(round);
          guard       <= '0;
          state       <= S_RUN;
        end
        S_RUN: begin
          if (guard != 2'd2) guard <= guard + 2'd1;
          // an answer in the same cycle as a timeout takes priority
          if (answer_valid || timeout) begin
            round_end   <= 1'b1;
            timer_reset <= 1'b1;
            frequency   <= FREQ_FROZEN;
            loading     <= 1'b1;
            dly_cnt     <= LOAD_INIT;
            state       <= S_LOAD;
            if (answer_valid) begin
              outcome <= answer_correct ? OUT_CORRECT : OUT_WRONG;
              if (answer_correct && score != 8'hFF) score <= score + 8'd1;
            end else begin
              outcome <= OUT_TIMEOUT;
            end
          end
        end
        S_LOAD: begin
          if (dly_cnt == '0) begin
            loading <= 1'b0;
            if (round == LAST_RND) begin
              game_over <= 1'b1;
              state     <= S_OVER;
            end else begin
              round     <= round + 4'd1;
              frequency <= run_speed(round + 4'd1);
              guard     <= '0;
              state     <= S_ARM;
            end
          end else begin
            dly_cnt <= dly_cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_round_controller.sv
// tb_round_controller: randomized game play against a round-level model
// (expected round/score/outcome tracked per round from the game rules),
// with a small behavioural countdown timer feeding time_up.
module tb_round_controller;
  localparam int NR = 3;
  localparam int FR = 1;
  localparam int LC = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       answer_valid = 1'b0;
  logic       answer_correct = 1'b0;
  logic       tu_force = 1'b0;
  logic       time_up;
  logic       timer_reset, loading, game_over, round_end;
  logic [1:0] frequency, outcome;
  logic [3:0] round;
  logic [7:0] score;

  int total = 0;
  int bad   = 0;
  int tcnt  = 0;
  int exp_score = 0;
  int exp_round = 0;

  always #5 clk = ~clk;

  round_controller #(.NUM_ROUNDS(NR), .FAST_ROUND(FR), .LOAD_CYCLES(LC), .CNT_W(28)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .answer_valid(answer_valid),
    .answer_correct(answer_correct), .time_up(time_up), .timer_reset(timer_reset),
    .frequency(frequency), .round(round), .score(score), .loading(loading),
    .game_over(game_over), .round_end(round_end), .outcome(outcome)
  );

  // timer model: held while timer_reset, counts down 12 (slow) or 6 (fast)
  always @(posedge clk) begin
    if (timer_reset) tcnt <= (frequency == 2'b11) ? 6 : 12;
    else if (tcnt != 0) tcnt <= tcnt - 1;
  end
  assign time_up = timer_reset | (tcnt == 0) | tu_force;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic int speed(input int r);
    return (r < FR) ? 0 : 3;
  endfunction

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic start_game;
    start = 1'b1;
    tick;
    start = 1'b0;
    exp_score = 0;
    exp_round = 0;
    chk("start_tr", timer_reset, 1);
    chk("start_round", round, 0);
    chk("start_score", score, 0);
    chk("start_over", game_over, 0);
    chk("start_outcome", outcome, 0);
    chk("start_freq", frequency, speed(0));
  endtask

  // kind: 0 correct, 1 wrong, 2 timeout, 3 early edge then timeout, 4 wrong+timeout same cycle
  task automatic play_round(input int kind, input bit reset_mid);
    int n, ends, d;
    bit ok;
    logic [1:0] exp_out;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (timer_reset == 1'b0) ok = 1'b1;
      else tick;
    end
    chk("run_reached", ok, 1);
    chk("run_round", round, exp_round);
    chk("run_freq", frequency, speed(exp_round));
    exp_out = 2'b11;
    case (kind)
      0, 1: begin
        d = $urandom_range(0, 4);
        repeat (d) tick;
        answer_valid = 1'b1;
        answer_correct = (kind == 0);
        tick;
        answer_valid = 1'b0;
        exp_out = (kind == 0) ? 2'b01 : 2'b10;
        if (kind == 0 && exp_score < 255) exp_score++;
      end
      4: begin
        tick;
        tick;
        tu_force = 1'b1;
        answer_valid = 1'b1;
        answer_correct = 1'b0;
        tick;
        tu_force = 1'b0;
        answer_valid = 1'b0;
        exp_out = 2'b10;
      end
      default: begin
        if (kind == 3) begin
          tick;
          tu_force = 1'b1;
          tick;
          tu_force = 1'b0;
          chk("guard_noend", round_end, 0);
        end else begin
          start = 1'b1;
          tick;
          start = 1'b0;
        end
        for (int i = 0; i < 40 && round_end !== 1'b1; i++) tick;
      end
    endcase
    chk("round_end", round_end, 1);
    chk("outcome", outcome, exp_out);
    chk("score", score, exp_score);
    n = 0;
    ends = 0;
    while (loading === 1'b1 && n < 20) begin
      n++;
      if (reset_mid && n == 2) begin
        reset_n = 1'b1;
        #1;
        chk("rst_loading", loading, 0);
        chk("rst_round", round, 0);
        chk("rst_end", round_end, 0);
        chk("rst_tr", timer_reset, 1);
        chk("rst_freq", frequency, 1);
        tick;
        reset_n = 1'b0;
        tick;
        chk("rst_idle_end", round_end, 0);
        chk("rst_idle_score", score, 0);
        return;
      end
      if (n == 1) begin answer_valid = 1'b1; answer_correct = 1'b1; end
      if (n == 3) start = 1'b1;
      tick;
      answer_valid = 1'b0;
      start = 1'b0;
      if (round_end === 1'b1) ends++;
    end
    chk("load_len", n, LC);
    chk("extra_end", ends, 0);
    chk("load_score", score, exp_score);
    if (exp_round == NR - 1) begin
      chk("over_flag", game_over, 1);
      chk("over_round", round, exp_round);
      chk("over_score", score, exp_score);
      answer_valid = 1'b1;
      answer_correct = 1'b1;
      tick;
      answer_valid = 1'b0;
      tick;
      chk("over_ignore", score, exp_score);
      chk("over_hold", game_over, 1);
    end else begin
      exp_round++;
      chk("arm_round", round, exp_round);
      chk("arm_tr", timer_reset, 1);
      chk("arm_freq", frequency, speed(exp_round));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b1;
    repeat (2) tick;
    reset_n = 1'b0;
    chk("rst_tr0", timer_reset, 1);
    chk("rst_freq0", frequency, 1);
    chk("rst_score0", score, 0);
    chk("rst_round0", round, 0);
    chk("rst_over0", game_over, 0);
    chk("rst_out0", outcome, 0);
    repeat (10) tick;
    chk("idle_tr", timer_reset, 1);
    chk("idle_freq", frequency, 1);
    chk("idle_end", round_end, 0);

    // directed game: correct, guarded timeout, correct
    start_game;
    play_round(0, 1'b0);
    play_round(3, 1'b0);
    play_round(0, 1'b0);

    // restart from OVER: collision, timeout, wrong
    start_game;
    play_round(4, 1'b0);
    play_round(2, 1'b0);
    play_round(1, 1'b0);

    // reset mid-LOAD, then resume
    start_game;
    play_round(0, 1'b1);
    start_game;
    for (int r = 0; r < NR; r++) play_round($urandom_range(0, 4), 1'b0);

    // random games
    repeat (3) begin
      start_game;
      for (int r = 0; r < NR; r++) play_round($urandom_range(0, 4), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/round_controller.md
Name: round_controller

Overview:
Game-flow controller on the driving side of the 30-second timer. It issues the timer's restart and speed-select inputs and consumes the timer's time_up. It also accepts player answers, keeps the round number and score, and sequences each round through arm, run, loading and game-over. It sits in the top module between the input/answer-check logic and the timer, and feeds the score and round displays.

Parameters:
NUM_ROUNDS, 10, rounds per game (1..15).
FAST_ROUND, 5, first round index (0-based) that uses the fast timer speed.
LOAD_CYCLES, 50_000_000, clk cycles spent in the loading phase between rounds (>=1).
CNT_W, 28, width of the loading-delay counter.

Ports:
clk  in  1  system clock.
reset_n  in  1  asynchronous, active-high reset. The port name follows the codebase, but asserting it high resets the block.
start  in  1  single-cycle pulse; begins a game from IDLE or OVER.
answer_valid  in  1  single-cycle pulse; the player submitted an answer.
answer_correct  in  1  qualifies answer_valid: 1 = correct.
time_up  in  1  from the timer; high while the timer is held in reset or has just expired.
timer_reset  out  1  drives the timer's reset input; 1 holds the timer at 30.
frequency  out  2  timer speed: 2'b00 slow, 2'b11 fast, 2'b01 frozen.
round  out  4  current round index, 0-based.
score  out  8  correct answers this game; saturates at 255.
loading  out  1  high during the between-round loading phase.
game_over  out  1  high in OVER.
round_end  out  1  single-cycle pulse when a round finishes.
outcome  out  2  result of the last round: 01 correct, 10 wrong, 11 timeout, 00 none. Holds until the next round_end.

Behaviour:
- Reset (asynchronous, on assertion) forces state IDLE and these outputs:
  - timer_reset=1, frequency=01
  - round=0, score=0
  - loading=0, game_over=0, round_end=0, outcome=00
  - delay counter=0
  - time_up history register=1
- States: IDLE, ARM, RUN, LOAD, OVER. All outputs are registered.
- IDLE: timer_reset=1, frequency=01.
  - On start: clear score, round and outcome; go to ARM next cycle.
- ARM: exactly one cycle. timer_reset=1, and frequency is the run speed for the current round. Clear the guard counter. Go to RUN.
- RUN: timer_reset=0, frequency = (round < FAST_ROUND) ? 00 : 11.
  - A 2-bit guard counter counts up from 0 and saturates at 2.
  - Timeout event: time_up=1 while the registered previous time_up=0 (a rising edge) and guard==2. Rising edges before guard==2 are ignored, because time_up is stale from the timer reset.
  - answer_valid: next cycle round_end=1; outcome=01 if answer_correct, else 10. If correct, score+1 (saturating at 255). Go to LOAD.
  - Timeout with no answer_valid: next cycle round_end=1, outcome=11, score unchanged. Go to LOAD.
  - answer_valid and a timeout in the same cycle: the answer wins and the timeout is discarded.
  - start in RUN is ignored.
- LOAD: timer_reset=1, frequency=01, loading=1.
  - The delay counter loads LOAD_CYCLES-1 on entry and decrements each cycle.
  - answer_valid and start are ignored.
  - When the counter reaches 0: if round==NUM_ROUNDS-1, go to OVER and leave round unchanged; otherwise round+1 and go to ARM.
- OVER: game_over=1, timer_reset=1, frequency=01. score and round hold.
  - On start: clear score, round and outcome; game_over=0; go to ARM.
- round_end is high for exactly one cycle per round.
- The block only updates round, score and outcome in the transitions stated above.
- Reset asserted in any state, including mid-LOAD, returns to IDLE on the spot. A partial delay count is discarded.

Test Plan:
Use LOAD_CYCLES=4, NUM_ROUNDS=3 and FAST_ROUND=1 in every scenario, with a behavioural timer model driving time_up.
1. Reset pulse then idle for 10 cycles -> timer_reset=1, frequency=01, score=0, round=0, game_over=0. start -> ARM for 1 cycle, then RUN with timer_reset=0 and frequency=00.
2. In round 0, answer_valid=1 with answer_correct=1 -> round_end pulse, outcome=01, score=1, loading=1 for exactly 4 cycles, then round=1 and frequency=11 in RUN.
3. In round 1, with no answer, the timer model raises time_up -> outcome=11, score unchanged at 1. Also drive time_up high in the first RUN cycle after ARM -> no round_end (guard check).
4. answer_valid (wrong) and a time_up rising edge in the same cycle -> a single round_end with outcome=10, score unchanged.
5. Finish round 2 with a correct answer -> after 4 loading cycles game_over=1, round=2, score=2, and answer_valid is ignored. start -> score=0, round=0, game_over=0, state ARM.
6. Assert reset two cycles into LOAD -> IDLE on the spot, loading=0, round=0, no round_end. A later start resumes normally.
